// File: rtl/conv3x3_seq_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : conv3x3_seq_ctrl_if
//  Brief    : Start/result handshake and SRAM read bus of the 3x3
//             convolution sequencer, grouped into one bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface conv3x3_seq_ctrl_if #(
  parameter int AW = 6
) ();
  // start side
  logic          i_en;
  logic [8:0]    kmask;
  // image SRAM read port
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [15:0]   mem_rdata;
  // result side
  logic [19:0]   result;
  logic          o_en;
  logic          busy;
  logic          done;

  // the sequencer drives addresses and results
  modport master (
    input  i_en, kmask, mem_rdata,
    output mem_addr, mem_rd, result, o_en, busy, done
  );

  // start logic, SRAM and result consumer
  modport slave (
    output i_en, kmask, mem_rdata,
    input  mem_addr, mem_rd, result, o_en, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/conv3x3_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : conv3x3_seq_ctrl
//  Brief    : Walks every valid 3x3 window of an IMG_W x IMG_H image in
//             row-major order, issues nine SRAM reads per window and sums
//             the kernel-masked pixels into a 20-bit result.
//  Revision : 1.0  initial release
// ============================================================================
module conv3x3_seq_ctrl #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  conv3x3_seq_ctrl_if.master bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;

  localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 3);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 3);
  localparam logic [3:0]    C_K_LAST   = 4'd8;

  // control state
  logic [1:0]    r_state;
  logic [3:0]    r_k;        // tap index 0..8 of the read being issued
  logic [1:0]    r_dr;       // k / 3, tracked incrementally
  logic [1:0]    r_dc;       // k % 3, tracked incrementally
  logic [RW-1:0] r_row;      // window top row
  logic [CW-1:0] r_col;      // window left column
  logic [8:0]    r_kmask;    // mask frozen at frame start

  // read-return pipeline: which tap the current mem_rdata belongs to
  logic          r_rd_d;
  logic [3:0]    r_kd;

  // datapath and outputs
  logic [19:0]   r_acc;
  logic [19:0]   r_result;
  logic          r_o_en;
  logic          r_done;

  logic          w_last_win;
  logic [19:0]   w_term;
  logic [19:0]   w_sum;
  logic [AW-1:0] w_addr;

  assign w_last_win = (r_row == C_ROW_LAST) && (r_col == C_COL_LAST);

  // masked pixel returned for the tap issued in the previous cycle
  assign w_term = r_kmask[r_kd] ? {4'd0, bus.mem_rdata} : 20'd0;
  assign w_sum  = r_acc + w_term;

  // window-relative address; forced to zero outside READ so idle/reset
  // present a quiet bus
  always_comb begin
    w_addr = '0;
    if (r_state == S_READ) begin
      w_addr = (AW'(r_row) + AW'(r_dr)) * AW'(IMG_W) + AW'(r_col) + AW'(r_dc);
    end
  end

  assign bus.mem_addr = w_addr;
  assign bus.mem_rd   = (r_state == S_READ);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.result   = r_result;
  assign bus.o_en     = r_o_en;
  assign bus.done     = r_done;

  // sequencer: IDLE -> READ (k = 0..8) -> LAST -> next window or IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= 4'd0;
      r_dr    <= 2'd0;
      r_dc    <= 2'd0;
      r_row   <= '0;
      r_col   <= '0;
      r_kmask <= 9'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_en) begin
            r_kmask <= bus.kmask;
            r_row   <= '0;
            r_col   <= '0;
            r_k     <= 4'd0;
            r_dr    <= 2'd0;
            r_dc    <= 2'd0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (r_k == C_K_LAST) begin
            r_state <= S_LAST;
          end else begin
            r_k <= r_k + 4'd1;
            if (r_dc == 2'd2) begin
              r_dc <= 2'd0;
              r_dr <= r_dr + 2'd1;
            end else begin
              r_dc <= r_dc + 2'd1;
            end
          end
        end
        S_LAST: begin
          r_k  <= 4'd0;
          r_dr <= 2'd0;
          r_dc <= 2'd0;
          if (w_last_win) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_READ;
            if (r_col == C_COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // remember which tap each read belongs to so data returning one cycle
  // later can be masked; cycles without a read leave the sum untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_d <= 1'b0;
      r_kd   <= 4'd0;
    end else begin
      r_rd_d <= (r_state == S_READ);
      r_kd   <= r_k;
    end
  end

  // accumulate returned pixels; tap 0 restarts the sum for a new window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= 20'd0;
    end else if (r_rd_d) begin
      r_acc <= (r_kd == 4'd0) ? w_term : w_sum;
    end
  end

  // LAST sees tap 8 data on the bus: fold it in and publish the window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= 20'd0;
      r_o_en   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_o_en <= (r_state == S_LAST);
      r_done <= (r_state == S_LAST) && w_last_win;
      if (r_state == S_LAST) begin
        r_result <= w_sum;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_conv3x3_seq_ctrl
//  Brief    : Directed self-checking bench for conv3x3_seq_ctrl on a 4x4
//             and an 8x8 image.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv3x3_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv3x3_seq_ctrl_if #(.AW(4)) bus4 ();
  conv3x3_seq_ctrl_if #(.AW(6)) bus8 ();

  conv3x3_seq_ctrl #(.IMG_W(4), .IMG_H(4), .AW(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  conv3x3_seq_ctrl #(.IMG_W(8), .IMG_H(8), .AW(6)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int errors = 0;
  int checks = 0;
  bit mem_ff = 1'b0;  // 1: every pixel 16'hFFFF, 0: pixel = address
  int exp_res [4];
  int addr0 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  function automatic logic [15:0] pix(input int a);
    return mem_ff ? 16'hFFFF : 16'(a);
  endfunction

  // SRAM models: one-cycle read latency, junk when no read was issued
  always @(posedge clk) bus4.mem_rdata <= bus4.mem_rd ? pix(int'(bus4.mem_addr)) : 16'($urandom);
  always @(posedge clk) bus8.mem_rdata <= bus8.mem_rd ? pix(int'(bus8.mem_addr)) : 16'($urandom);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One 4x4 frame, checked every cycle 1..41 at the falling edge.
  task automatic run4(input logic [8:0] km, input bit poke, input bit chained_in,
                      input bit chain_out, input logic [8:0] km_next);
    if (!chained_in) begin
      @(negedge clk);
      bus4.i_en  = 1'b1;
      bus4.kmask = km;
    end
    for (int c = 1; c <= 41; c++) begin
      @(negedge clk);
      bus4.i_en = 1'b0;
      if (c <= 9) begin
        check("mem_rd_read", bus4.mem_rd, 1);
        check("mem_addr_w0", bus4.mem_addr, addr0[c-1]);
      end
      if (c == 10) check("mem_rd_last", bus4.mem_rd, 0);
      check("busy", bus4.busy, (c <= 40));
      check("o_en", bus4.o_en, (c > 1 && c % 10 == 1));
      check("done", bus4.done, (c == 41));
      if (c > 1 && c % 10 == 1) check("result", bus4.result, exp_res[c/10-1]);
      if (poke && (c == 5 || c == 25)) begin
        bus4.i_en  = 1'b1;
        bus4.kmask = ~km;
      end
      if (chain_out && c == 41) begin
        bus4.i_en  = 1'b1;
        bus4.kmask = km_next;
      end
    end
  endtask

  initial begin
    int n_oen, busy_bad, done_cnt, done_cyc, bad_after;
    logic [19:0] first_res, last_res;

    bus4.i_en = 1'b0; bus4.kmask = 9'd0;
    bus8.i_en = 1'b0; bus8.kmask = 9'd0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_mem_addr", bus4.mem_addr, 0);
    check("rst_mem_rd",   bus4.mem_rd,   0);
    check("rst_result",   bus4.result,   0);
    check("rst_o_en",     bus4.o_en,     0);
    check("rst_busy",     bus4.busy,     0);
    check("rst_done",     bus4.done,     0);
    check("rst8_busy",    bus8.busy,     0);
    rst = 1'b0;
    @(negedge clk);

    // full kernel, pixel = address
    exp_res = '{45, 54, 81, 90};
    run4(9'h1FF, 1'b0, 1'b0, 1'b0, 9'h000);

    // centre tap only
    exp_res = '{5, 6, 9, 10};
    run4(9'h010, 1'b0, 1'b0, 1'b0, 9'h000);

    // saturated image: maximum sum, no wrap
    mem_ff  = 1'b1;
    exp_res = '{32'h8FFF7, 32'h8FFF7, 32'h8FFF7, 32'h8FFF7};
    run4(9'h1FF, 1'b0, 1'b0, 1'b0, 9'h000);
    mem_ff  = 1'b0;

    // empty kernel still pulses with zero result
    exp_res = '{0, 0, 0, 0};
    run4(9'h000, 1'b0, 1'b0, 1'b0, 9'h000);

    // start pulses and kmask changes mid-frame are ignored
    exp_res = '{45, 54, 81, 90};
    run4(9'h1FF, 1'b1, 1'b0, 1'b0, 9'h000);

    // start in the done cycle chains a new frame with no gap
    exp_res = '{5, 6, 9, 10};
    run4(9'h010, 1'b0, 1'b0, 1'b1, 9'h1FF);
    exp_res = '{45, 54, 81, 90};
    run4(9'h1FF, 1'b0, 1'b1, 1'b0, 9'h000);

    // asynchronous reset in cycle 15 of a frame
    @(negedge clk);
    bus4.i_en  = 1'b1;
    bus4.kmask = 9'h1FF;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      bus4.i_en = 1'b0;
      if (c == 11) check("pre_rst_result", bus4.result, 45);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_mem_addr", bus4.mem_addr, 0);
    check("arst_mem_rd",   bus4.mem_rd,   0);
    check("arst_result",   bus4.result,   0);
    check("arst_o_en",     bus4.o_en,     0);
    check("arst_busy",     bus4.busy,     0);
    check("arst_done",     bus4.done,     0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad_after = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus4.o_en !== 1'b0 || bus4.busy !== 1'b0 || bus4.mem_rd !== 1'b0) bad_after++;
    end
    check("post_rst_quiet", bad_after, 0);
    run4(9'h1FF, 1'b0, 1'b0, 1'b0, 9'h000);

    // default-size 8x8 frame
    n_oen = 0; busy_bad = 0; done_cnt = 0; done_cyc = 0;
    first_res = '0; last_res = '0;
    @(negedge clk);
    bus8.i_en  = 1'b1;
    bus8.kmask = 9'h1FF;
    for (int c = 1; c <= 370; c++) begin
      @(negedge clk);
      bus8.i_en = 1'b0;
      if (bus8.busy !== (c <= 360)) busy_bad++;
      if (bus8.o_en === 1'b1) begin
        n_oen++;
        if (n_oen == 1) first_res = bus8.result;
        last_res = bus8.result;
      end
      if (bus8.done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
    end
    check("img8_o_en_count", n_oen, 36);
    check("img8_busy_window", busy_bad, 0);
    check("img8_done_count", done_cnt, 1);
    check("img8_done_cycle", done_cyc, 361);
    check("img8_first_result", first_res, 81);
    check("img8_last_result", last_res, 486);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv3x3_seq_ctrl.md
# conv3x3_seq_ctrl

Sequencer that drives the 3x3 convolution datapath over an image held in a 16-bit single-port SRAM. On a one-cycle `i_en` start pulse it walks every valid (unpadded) 3x3 window of an IMG_W x IMG_H image in row-major order. For each window it issues nine SRAM reads and accumulates the kernel-masked pixels into a 20-bit `result`, then strobes `o_en`. It sits between the start/enable logic and the image SRAM and replaces free-running counter addressing with window-aware address generation.

## Interface
- IMG_W, 8, image width in pixels (>= 3)
- IMG_H, 8, image height in pixels (>= 3)
- AW, 6, SRAM address width; must satisfy 2^AW >= IMG_W*IMG_H
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset, asynchronous and active-high
- i_en  in  1  start pulse; sampled only in IDLE
- kmask  in  9  kernel mask; bit k = dr*3+dc includes the pixel at offset (dr,dc); captured at start
- mem_addr  out  AW  SRAM read address
- mem_rd  out  1  SRAM read strobe
- mem_rdata  in  16  SRAM read data; valid the cycle after `mem_rd`
- result  out  20  window sum; held until the next `o_en`
- o_en  out  1  one-cycle strobe; `result` is valid while it is high
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle strobe coincident with the frame's final `o_en`

## Operation
- States: IDLE, READ (k = 0..8), LAST.
- IDLE: if `i_en` = 1 at a clock edge:
  - capture `kmask`;
  - set row = 0, col = 0, k = 0;
  - go to READ.
- READ: `mem_rd` = 1, `mem_addr` = (row + k/3)*IMG_W + (col + k%3). k increments each cycle. After k = 8 go to LAST.
- LAST: `mem_rd` = 0. Capture the k = 8 data, then register the total into `result`.
  - If (row, col) is not the last window: advance col. If col wraps past IMG_W-3, set col = 0 and increment row. Go to READ with k = 0.
  - Else go to IDLE.
- Accumulator, driven by data arriving for read k:
  - k = 0: acc loads (kmask[0] ? data : 0);
  - k = 1..8: acc += (kmask[k] ? data : 0).
- Width: acc and `result` are 20 bits, unsigned, zero-extended. The maximum is 9*65535 = 589815, so overflow is impossible.
- Output count per frame: (IMG_W-2)*(IMG_H-2). Windows never cross the right or bottom border; there is no padding.
- `i_en` while `busy` = 1 is ignored and has no side effects.
- kmask = 0: reads are still issued, `result` = 0, and `o_en` still pulses.
- `mem_rdata` is ignored whenever no read was issued in the previous cycle.

## Timing
- Cycle 0 is the edge that samples `i_en` = 1. READ runs cycles 1-9 (k = 0..8). LAST is cycle 10. Data for read k is captured at the end of cycle k+2.
- `result` is updated at the end of cycle 10 + 10n; `o_en` is high in cycle 11 + 10n for window n (n = 0..N-1).
- Throughput: 10 cycles per window. The next window's k = 0 read is issued in the same cycle as the previous window's `o_en`.
- `busy` is high from cycle 1 through cycle 10N. It is low in the final `o_en`/`done` cycle (11 + 10(N-1)), when the FSM is already in IDLE.
- A start pulse in the `done` cycle is accepted. It starts a new frame with no gap.
- Reset values:
  - `mem_addr` = 0, `mem_rd` = 0, `result` = 0;
  - `o_en` = 0, `busy` = 0, `done` = 0;
  - FSM in IDLE, acc = 0, counters = 0.
- Reset mid-frame: all outputs clear immediately (asynchronous), the partial sum is discarded, and no `o_en` is emitted for it. After release, the block waits in IDLE for a new `i_en`.

## Test plan
- IMG_W = IMG_H = 4, SRAM[a] = a, kmask = 9'h1FF, `i_en` pulse at cycle 0 -> `o_en` in cycles 11/21/31/41 with `result` = 45/54/81/90. `done` is high in cycle 41. `mem_addr` sequence for window 0 is 0,1,2,4,5,6,8,9,10.
- Same image, kmask = 9'b000010000 -> `result` = 5, 6, 9, 10.
- Same image, all SRAM = 16'hFFFF, kmask = 9'h1FF -> every `result` = 20'h8FFF7. No wrap.
- Default 8x8 image -> exactly 36 `o_en` pulses. `busy` is high for cycles 1..360; `done` is high in cycle 361 only.
- `i_en` pulsed again at cycles 5 and 25 -> ignored. Output count and values are unchanged, and `kmask` changes after start have no effect.
- `rst` asserted in cycle 15 for two cycles -> all outputs 0 at once and no further `o_en`. A new `i_en` then reproduces 45/54/81/90 at the expected offsets.
